sram_port_sched: RTL and testbench

Front-end scheduler for one port of the core's dual-port byte-masked SRAM macros (cache data/tag arrays). It arbitrates two requestors onto the port: a high-priority load path (A) and a low-priority fill/store path (B), with starvation protection. It drives the RAM's registered active-low control inputs and tracks in-flight reads through the macro's fixed read latency so that responses carry source and ID. After reset, or on request, it zero-initialises the whole array.

---
 rtl/SramPortPkg.sv | 35 +++
 rtl/sram_port_arb.sv | 41 ++++
 rtl/sram_port_sched.sv | 169 ++++++++++++++++
 tb/tb_sram_port_sched.sv | 366 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/SramPortPkg.sv
// Shared types and constants for the SRAM port scheduler.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package SramPortPkg;

   // Cycles from grant to response on the RAM read path.
   localparam int SRAM_RD_LAT = 3;

   // Field widths of the shared request/tracker records. Addresses are carried
   // at a fixed maximum width and narrowed at the port.
   localparam int SPS_AW_MAX = 16;
   localparam int SPS_DATA_W = 256;
   localparam int SPS_MASK_W = 32;
   localparam int SPS_ID_W   = 4;

   typedef enum logic [0:0] {
      SPS_INIT = 1'b0,
      SPS_RUN  = 1'b1
   } sps_state_t;

   typedef struct packed {
      logic                  we;
      logic [SPS_AW_MAX-1:0] addr;
      logic [SPS_DATA_W-1:0] data;
      logic [SPS_MASK_W-1:0] wm;
      logic [SPS_ID_W-1:0]   id;
   } sps_req_t;

   typedef struct packed {
      logic                valid;
      logic                src;
      logic [SPS_ID_W-1:0] id;
   } sps_trk_t;

endpackage

// File: rtl/sram_port_arb.sv
// Two-way priority arbiter: A preferred, B forced after STARVE_LIMIT A-wins.
// Latency: grants are combinational from valids; only the starve count is registered.
// Backpressure: readies drop to 0 while not running; A stalls while B is forced.
module sram_port_arb
#(
   parameter int STARVE_LIMIT = 4
)(
   input  logic clk,
   input  logic rst_n,
   input  logic run,
   input  logic a_valid,
   input  logic b_valid,
   output logic a_ready,
   output logic b_ready,
   output logic grant_a,
   output logic grant_b
);

   localparam int CW = $clog2(STARVE_LIMIT + 1);

   logic [CW-1:0] starve_cnt;
   logic          force_b;

   assign force_b = (starve_cnt == CW'(STARVE_LIMIT));
   assign a_ready = run && !force_b;
   assign b_ready = run && (force_b || !a_valid);
   assign grant_a = a_ready && a_valid;
   assign grant_b = b_ready && b_valid;

   // Count A-wins over a waiting B; any B win or an idle B resets the count.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         starve_cnt <= '0;
      end else if (grant_b || !b_valid) begin
         starve_cnt <= '0;
      end else if (grant_a && !force_b) begin
         starve_cnt <= starve_cnt + CW'(1);
      end
   end

endmodule

// File: rtl/sram_port_sched.sv
// Single-port SRAM scheduler: arbitrates A/B, zero-sweeps the array, tags reads.
// Latency: grant -> RAM pins +1 cycle, grant -> response +SRAM_RD_LAT cycles.
// Backpressure: readies low during the sweep; responses cannot be stalled.
module sram_port_sched
   import SramPortPkg::*;
#(
   parameter  int WORD_SIZE    = 256,
   parameter  int NUM_WORDS    = 512,
   parameter  int WRITE_SIZE   = 8,
   parameter  int ID_W         = 4,
   parameter  int STARVE_LIMIT = 4,
   localparam int AW           = $clog2(NUM_WORDS),
   localparam int MW           = WORD_SIZE / WRITE_SIZE
)(
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 IN_reqA_valid,
   output logic                 OUT_reqA_ready,
   input  logic                 IN_reqA_we,
   input  logic [AW-1:0]        IN_reqA_addr,
   input  logic [WORD_SIZE-1:0] IN_reqA_data,
   input  logic [MW-1:0]        IN_reqA_wm,
   input  logic [ID_W-1:0]      IN_reqA_id,
   input  logic                 IN_reqB_valid,
   output logic                 OUT_reqB_ready,
   input  logic                 IN_reqB_we,
   input  logic [AW-1:0]        IN_reqB_addr,
   input  logic [WORD_SIZE-1:0] IN_reqB_data,
   input  logic [MW-1:0]        IN_reqB_wm,
   input  logic [ID_W-1:0]      IN_reqB_id,
   input  logic                 IN_init,
   output logic                 OUT_nce,
   output logic                 OUT_nwe,
   output logic [AW-1:0]        OUT_addr,
   output logic [WORD_SIZE-1:0] OUT_data,
   output logic [MW-1:0]        OUT_wm,
   input  logic [WORD_SIZE-1:0] IN_rdata,
   output logic                 OUT_resp_valid,
   output logic                 OUT_resp_src,
   output logic [ID_W-1:0]      OUT_resp_id,
   output logic [WORD_SIZE-1:0] OUT_resp_data,
   output logic                 OUT_initDone
);

   sps_state_t     state;
   logic [AW-1:0]  sweep_addr;
   logic           run;
   logic           grant_a;
   logic           grant_b;
   logic           any_grant;
   sps_req_t       sel_req;
   sps_trk_t       trk [SRAM_RD_LAT];

   logic                 nce_q;
   logic                 nwe_q;
   logic [AW-1:0]        addr_q;
   logic [WORD_SIZE-1:0] data_q;
   logic [MW-1:0]        wm_q;

   // Address bits above AW are zero-extension only.
   logic unused_sel_addr;
   assign unused_sel_addr = ^sel_req.addr;

   assign run       = (state == SPS_RUN);
   assign any_grant = grant_a || grant_b;

   sram_port_arb #(
      .STARVE_LIMIT (STARVE_LIMIT)
   ) u_arb (
      .clk     (clk),
      .rst_n   (rst_n),
      .run     (run),
      .a_valid (IN_reqA_valid),
      .b_valid (IN_reqB_valid),
      .a_ready (OUT_reqA_ready),
      .b_ready (OUT_reqB_ready),
      .grant_a (grant_a),
      .grant_b (grant_b)
   );

   // Route whichever requestor won into the common request record.
   always_comb begin
      sel_req = '0;
      if (grant_b) begin
         sel_req.we   = IN_reqB_we;
         sel_req.addr = SPS_AW_MAX'(IN_reqB_addr);
         sel_req.data = SPS_DATA_W'(IN_reqB_data);
         sel_req.wm   = SPS_MASK_W'(IN_reqB_wm);
         sel_req.id   = SPS_ID_W'(IN_reqB_id);
      end else begin
         sel_req.we   = IN_reqA_we;
         sel_req.addr = SPS_AW_MAX'(IN_reqA_addr);
         sel_req.data = SPS_DATA_W'(IN_reqA_data);
         sel_req.wm   = SPS_MASK_W'(IN_reqA_wm);
         sel_req.id   = SPS_ID_W'(IN_reqA_id);
      end
   end

   // INIT walks every address once, then RUN until an init pulse restarts it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= SPS_INIT;
         sweep_addr <= '0;
      end else if (state == SPS_INIT) begin
         if (sweep_addr == AW'(NUM_WORDS - 1)) begin
            state      <= SPS_RUN;
            sweep_addr <= '0;
         end else begin
            sweep_addr <= sweep_addr + AW'(1);
         end
      end else if (IN_init) begin
         state      <= SPS_INIT;
         sweep_addr <= '0;
      end
   end

   // Register RAM controls: sweep write, granted access, or deselect with held fields.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         nce_q  <= 1'b1;
         nwe_q  <= 1'b1;
         addr_q <= '0;
         data_q <= '0;
         wm_q   <= '0;
      end else if (!run) begin
         nce_q  <= 1'b0;
         nwe_q  <= 1'b0;
         addr_q <= sweep_addr;
         data_q <= '0;
         wm_q   <= '1;
      end else if (any_grant) begin
         nce_q  <= 1'b0;
         nwe_q  <= !sel_req.we;
         addr_q <= AW'(sel_req.addr);
         data_q <= WORD_SIZE'(sel_req.data);
         wm_q   <= MW'(sel_req.wm);
      end else begin
         nce_q  <= 1'b1;
      end
   end

   // Shift read tags alongside the RAM pipeline; writes and sweep slots enter empty.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < SRAM_RD_LAT; i++) begin
            trk[i] <= '0;
         end
      end else begin
         trk[0].valid <= any_grant && !sel_req.we;
         trk[0].src   <= grant_b;
         trk[0].id    <= sel_req.id;
         for (int i = 1; i < SRAM_RD_LAT; i++) begin
            trk[i] <= trk[i-1];
         end
      end
   end

   assign OUT_nce        = nce_q;
   assign OUT_nwe        = nwe_q;
   assign OUT_addr       = addr_q;
   assign OUT_data       = data_q;
   assign OUT_wm         = wm_q;
   assign OUT_resp_valid = trk[SRAM_RD_LAT-1].valid;
   assign OUT_resp_src   = trk[SRAM_RD_LAT-1].src;
   assign OUT_resp_id    = ID_W'(trk[SRAM_RD_LAT-1].id);
   assign OUT_resp_data  = IN_rdata;
   assign OUT_initDone   = run;

endmodule

// File: tb/tb_sram_port_sched.sv
// Bench for sram_port_sched with a RAM model and a transaction-level reference.
// Latency: reference expects pins one cycle and responses three cycles after grant.
// Backpressure: random valids; readies checked against the priority/starvation rules.
module tb_sram_port_sched;

   localparam int NW  = 16;
   localparam int WS  = 256;
   localparam int WRS = 8;
   localparam int IDW = 4;
   localparam int SL  = 4;
   localparam int AW  = $clog2(NW);
   localparam int MW  = WS / WRS;

   logic           clk = 1'b0;
   logic           rst_n;
   logic           IN_reqA_valid, IN_reqA_we;
   logic [AW-1:0]  IN_reqA_addr;
   logic [WS-1:0]  IN_reqA_data;
   logic [MW-1:0]  IN_reqA_wm;
   logic [IDW-1:0] IN_reqA_id;
   logic           IN_reqB_valid, IN_reqB_we;
   logic [AW-1:0]  IN_reqB_addr;
   logic [WS-1:0]  IN_reqB_data;
   logic [MW-1:0]  IN_reqB_wm;
   logic [IDW-1:0] IN_reqB_id;
   logic           IN_init;
   logic           OUT_reqA_ready, OUT_reqB_ready;
   logic           OUT_nce, OUT_nwe;
   logic [AW-1:0]  OUT_addr;
   logic [WS-1:0]  OUT_data;
   logic [MW-1:0]  OUT_wm;
   logic [WS-1:0]  ram_rdata;
   logic           OUT_resp_valid, OUT_resp_src;
   logic [IDW-1:0] OUT_resp_id;
   logic [WS-1:0]  OUT_resp_data;
   logic           OUT_initDone;

   int n_cmp = 0;
   int n_bad = 0;

   sram_port_sched #(
      .WORD_SIZE    (WS),
      .NUM_WORDS    (NW),
      .WRITE_SIZE   (WRS),
      .ID_W         (IDW),
      .STARVE_LIMIT (SL)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .IN_reqA_valid  (IN_reqA_valid),
      .OUT_reqA_ready (OUT_reqA_ready),
      .IN_reqA_we     (IN_reqA_we),
      .IN_reqA_addr   (IN_reqA_addr),
      .IN_reqA_data   (IN_reqA_data),
      .IN_reqA_wm     (IN_reqA_wm),
      .IN_reqA_id     (IN_reqA_id),
      .IN_reqB_valid  (IN_reqB_valid),
      .OUT_reqB_ready (OUT_reqB_ready),
      .IN_reqB_we     (IN_reqB_we),
      .IN_reqB_addr   (IN_reqB_addr),
      .IN_reqB_data   (IN_reqB_data),
      .IN_reqB_wm     (IN_reqB_wm),
      .IN_reqB_id     (IN_reqB_id),
      .IN_init        (IN_init),
      .OUT_nce        (OUT_nce),
      .OUT_nwe        (OUT_nwe),
      .OUT_addr       (OUT_addr),
      .OUT_data       (OUT_data),
      .OUT_wm         (OUT_wm),
      .IN_rdata       (ram_rdata),
      .OUT_resp_valid (OUT_resp_valid),
      .OUT_resp_src   (OUT_resp_src),
      .OUT_resp_id    (OUT_resp_id),
      .OUT_resp_data  (OUT_resp_data),
      .OUT_initDone   (OUT_initDone)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [WS-1:0] act, input logic [WS-1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
      end
   endtask

   function automatic logic [WS-1:0] merge(input logic [WS-1:0] old, input logic [WS-1:0] d,
                                           input logic [MW-1:0] m);
      logic [WS-1:0] r;
      r = old;
      for (int i = 0; i < MW; i++) begin
         if (m[i]) r[i*WRS +: WRS] = d[i*WRS +: WRS];
      end
      return r;
   endfunction

   // RAM macro: controls registered at the edge, access performed one edge later.
   logic [WS-1:0] ram [NW];
   logic          r_vld = 1'b0;
   logic          r_we;
   logic [AW-1:0] r_addr;
   logic [WS-1:0] r_data;
   logic [MW-1:0] r_wm;
   always @(posedge clk) begin
      if (r_vld) begin
         if (r_we) begin
            for (int i = 0; i < MW; i++) begin
               if (r_wm[i]) ram[r_addr][i*WRS +: WRS] <= r_data[i*WRS +: WRS];
            end
         end else begin
            ram_rdata <= ram[r_addr];
         end
      end
      r_vld  <= !OUT_nce;
      r_we   <= !OUT_nwe;
      r_addr <= OUT_addr;
      r_data <= OUT_data;
      r_wm   <= OUT_wm;
   end

   // Reference model: memory image updated in grant order, responses queued by due cycle.
   typedef struct {
      int             due;
      logic           src;
      logic [IDW-1:0] id;
      logic [WS-1:0]  data;
   } rsp_t;

   rsp_t          q [$];
   logic [WS-1:0] mem_m [NW];
   bit            m_run;
   int            m_sweep, m_starve, mcyc;
   logic          e_nce, e_nwe;
   logic [AW-1:0] e_addr;
   logic [WS-1:0] e_data;
   logic [MW-1:0] e_wm;

   // Compare every cycle mid-period, then advance the model by one cycle.
   always @(negedge clk) begin
      logic           ea, eb, ga, gb, rwe;
      logic [AW-1:0]  raddr;
      logic [WS-1:0]  rdat;
      logic [MW-1:0]  rwm;
      logic [IDW-1:0] rid;
      rsp_t           r;
      if (!rst_n) begin
         m_run = 0; m_sweep = 0; m_starve = 0; mcyc = 0;
         q.delete();
         e_nce = 1'b1; e_nwe = 1'b1; e_addr = '0; e_data = '0; e_wm = '0;
         chk("rst_nce",     WS'(OUT_nce),        WS'(1));
         chk("rst_nwe",     WS'(OUT_nwe),        WS'(1));
         chk("rst_addr",    WS'(OUT_addr),       WS'(0));
         chk("rst_wm",      WS'(OUT_wm),         WS'(0));
         chk("rst_data",    OUT_data,            WS'(0));
         chk("rst_resp",    WS'(OUT_resp_valid), WS'(0));
         chk("rst_rdyA",    WS'(OUT_reqA_ready), WS'(0));
         chk("rst_rdyB",    WS'(OUT_reqB_ready), WS'(0));
         chk("rst_initdn",  WS'(OUT_initDone),   WS'(0));
      end else begin
         ea = m_run && (m_starve != SL);
         eb = m_run && ((m_starve == SL) || !IN_reqA_valid);
         chk("m_rdyA",   WS'(OUT_reqA_ready), WS'(ea));
         chk("m_rdyB",   WS'(OUT_reqB_ready), WS'(eb));
         chk("m_initdn", WS'(OUT_initDone),   WS'(m_run));
         chk("m_nce",    WS'(OUT_nce),        WS'(e_nce));
         chk("m_nwe",    WS'(OUT_nwe),        WS'(e_nwe));
         chk("m_addr",   WS'(OUT_addr),       WS'(e_addr));
         chk("m_data",   OUT_data,            e_data);
         chk("m_wm",     WS'(OUT_wm),         WS'(e_wm));
         if (q.size() > 0 && q[0].due == mcyc) begin
            r = q.pop_front();
            chk("m_resp_vld",  WS'(OUT_resp_valid), WS'(1));
            chk("m_resp_src",  WS'(OUT_resp_src),   WS'(r.src));
            chk("m_resp_id",   WS'(OUT_resp_id),    WS'(r.id));
            chk("m_resp_data", OUT_resp_data,       r.data);
         end else begin
            chk("m_resp_vld",  WS'(OUT_resp_valid), WS'(0));
         end
         ga = ea && IN_reqA_valid;
         gb = eb && IN_reqB_valid;
         if (!m_run) begin
            e_nce = 1'b0; e_nwe = 1'b0; e_addr = AW'(m_sweep); e_data = '0; e_wm = '1;
            mem_m[m_sweep] = '0;
            m_sweep++;
            if (m_sweep == NW) begin m_run = 1; m_sweep = 0; end
            if (!IN_reqB_valid) m_starve = 0;
         end else begin
            if (gb || !IN_reqB_valid) m_starve = 0;
            else if (ga && m_starve < SL) m_starve++;
            if (ga || gb) begin
               if (gb) begin
                  rwe = IN_reqB_we; raddr = IN_reqB_addr; rdat = IN_reqB_data;
                  rwm = IN_reqB_wm; rid = IN_reqB_id;
               end else begin
                  rwe = IN_reqA_we; raddr = IN_reqA_addr; rdat = IN_reqA_data;
                  rwm = IN_reqA_wm; rid = IN_reqA_id;
               end
               e_nce = 1'b0; e_nwe = !rwe; e_addr = raddr; e_data = rdat; e_wm = rwm;
               if (rwe) begin
                  mem_m[raddr] = merge(mem_m[raddr], rdat, rwm);
               end else begin
                  r.due = mcyc + 3; r.src = gb; r.id = rid; r.data = mem_m[raddr];
                  q.push_back(r);
               end
            end else begin
               e_nce = 1'b1;
            end
            if (IN_init) begin m_run = 0; m_sweep = 0; end
         end
         mcyc++;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drv_a(input logic v, input logic we, input int addr, input logic [WS-1:0] d,
                        input logic [MW-1:0] wm, input int id);
      IN_reqA_valid = v; IN_reqA_we = we; IN_reqA_addr = AW'(addr);
      IN_reqA_data = d; IN_reqA_wm = wm; IN_reqA_id = IDW'(id);
   endtask

   task automatic drv_b(input logic v, input logic we, input int addr, input logic [WS-1:0] d,
                        input logic [MW-1:0] wm, input int id);
      IN_reqB_valid = v; IN_reqB_we = we; IN_reqB_addr = AW'(addr);
      IN_reqB_data = d; IN_reqB_wm = wm; IN_reqB_id = IDW'(id);
   endtask

   function automatic logic [WS-1:0] rnd_word();
      return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
   endfunction

   initial begin
      logic [AW-1:0] pat [10];
      logic          srcs [10];
      int            nr, nlow;
      int            pa [3];
      int            pb [3];
      rst_n = 1'b0;
      IN_init = 1'b0;
      drv_a(0, 0, 0, '0, '0, 0);
      drv_b(0, 0, 0, '0, '0, 0);
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      drv_a(1, 0, 2, '0, '0, 1);
      drv_b(1, 0, 3, '0, '0, 2);

      // Sweep after reset: writes 0..15 on pins in cycles 1..16, done in cycle 16.
      for (int k = 0; k <= NW; k++) begin
         if (k > 0) tick();
         if (k == NW) begin IN_reqA_valid = 0; IN_reqB_valid = 0; end
         @(negedge clk);
         if (k >= 1) begin
            chk("sweep_nce",  WS'(OUT_nce),  WS'(0));
            chk("sweep_nwe",  WS'(OUT_nwe),  WS'(0));
            chk("sweep_addr", WS'(OUT_addr), WS'(k - 1));
            chk("sweep_wm",   WS'(OUT_wm),   WS'(32'hFFFF_FFFF));
            chk("sweep_data", OUT_data,      WS'(0));
         end
         chk("sweep_initdn", WS'(OUT_initDone), WS'(k == NW));
         if (k < NW) begin
            chk("sweep_rdyA", WS'(OUT_reqA_ready), WS'(0));
            chk("sweep_rdyB", WS'(OUT_reqB_ready), WS'(0));
         end
      end

      // A reads addr 5 id 3; response three cycles after the grant.
      tick(); drv_a(1, 0, 5, '0, '0, 3);
      tick(); IN_reqA_valid = 0;
      @(negedge clk);
      chk("rdA_pin_addr", WS'(OUT_addr), WS'(5));
      chk("rdA_pin_nwe",  WS'(OUT_nwe),  WS'(1));
      tick(); tick();
      @(negedge clk);
      chk("rdA_vld",  WS'(OUT_resp_valid), WS'(1));
      chk("rdA_src",  WS'(OUT_resp_src),   WS'(0));
      chk("rdA_id",   WS'(OUT_resp_id),    WS'(3));
      chk("rdA_data", OUT_resp_data,       WS'(0));

      // A writes 0xAB into byte 0 of addr 7, B reads it the very next cycle.
      tick(); drv_a(1, 1, 7, WS'(8'hAB), MW'(1), 0);
      tick(); IN_reqA_valid = 0; drv_b(1, 0, 7, '0, '0, 9);
      tick(); IN_reqB_valid = 0;
      tick(); tick();
      @(negedge clk);
      chk("wr_rd_vld",  WS'(OUT_resp_valid), WS'(1));
      chk("wr_rd_src",  WS'(OUT_resp_src),   WS'(1));
      chk("wr_rd_id",   WS'(OUT_resp_id),    WS'(9));
      chk("wr_rd_data", OUT_resp_data,       WS'(8'hAB));

      // Both requestors saturated: AAAAB repeating, responses in grant order.
      tick(); tick();
      pat = '{4'd1, 4'd1, 4'd1, 4'd1, 4'd2, 4'd1, 4'd1, 4'd1, 4'd1, 4'd2};
      drv_a(1, 0, 1, '0, '0, 1);
      drv_b(1, 0, 2, '0, '0, 2);
      nr = 0;
      for (int i = 0; i < 13; i++) begin
         tick();
         if (i == 9) begin IN_reqA_valid = 0; IN_reqB_valid = 0; end
         @(negedge clk);
         if (i < 10) chk("aaaab_addr", WS'(OUT_addr), WS'(pat[i]));
         if (OUT_resp_valid) begin
            if (nr < 10) srcs[nr] = OUT_resp_src;
            nr++;
         end
      end
      chk("aaaab_nresp", WS'(nr), WS'(10));
      for (int i = 0; i < 10; i++) chk("aaaab_src", WS'(srcs[i]), WS'(pat[i] == 2));

      // Init pulse with two reads in flight: both return, then a full sweep.
      tick(); drv_a(1, 0, 3, '0, '0, 4);
      tick(); drv_a(1, 0, 4, '0, '0, 5); IN_init = 1;
      tick(); IN_reqA_valid = 0; IN_init = 0;
      nr = 0; nlow = 0;
      for (int i = 0; i < 19; i++) begin
         @(negedge clk);
         if (OUT_resp_valid) nr++;
         if (!OUT_initDone) nlow++;
         if (i == 18) chk("init_done_back", WS'(OUT_initDone), WS'(1));
         tick();
      end
      chk("init_nresp", WS'(nr),   WS'(2));
      chk("init_nlow",  WS'(nlow), WS'(NW));

      // Reset while a response is on the outputs: dropped at once, never reappears.
      drv_a(1, 0, 6, '0, '0, 7);
      tick(); drv_a(1, 0, 8, '0, '0, 8);
      tick(); IN_reqA_valid = 0;
      tick(); rst_n = 0;
      @(negedge clk);
      chk("midrst_resp", WS'(OUT_resp_valid), WS'(0));
      chk("midrst_nce",  WS'(OUT_nce),        WS'(1));
      tick(); tick(); rst_n = 1;
      nr = 0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (OUT_resp_valid) nr++;
         tick();
      end
      chk("midrst_stale", WS'(nr), WS'(0));

      // Randomised traffic in three load profiles with occasional init pulses.
      pa = '{60, 95, 30};
      pb = '{50, 95, 80};
      for (int ph = 0; ph < 3; ph++) begin
         for (int n = 0; n < 600; n++) begin
            drv_a($urandom_range(0, 99) < pa[ph], 1'($urandom), $urandom_range(0, NW - 1),
                  rnd_word(), MW'($urandom), $urandom_range(0, 15));
            drv_b($urandom_range(0, 99) < pb[ph], 1'($urandom), $urandom_range(0, NW - 1),
                  rnd_word(), MW'($urandom), $urandom_range(0, 15));
            IN_init = ($urandom_range(0, 299) == 0);
            tick();
         end
      end
      IN_reqA_valid = 0; IN_reqB_valid = 0; IN_init = 0;
      repeat (24) tick();
      @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
